// File: rtl/pwm_frame_ctrl_if.sv
// Upstream pixel-word stream into the PWM frame controller (valid/ready).
interface pwm_frame_ctrl_if #(
  parameter int DWIDTH = 8
);
  logic              s_valid;
  logic [DWIDTH-1:0] s_data;
  logic              s_ready;

  modport master (output s_valid, output s_data, input s_ready);
  modport slave  (input s_valid, input s_data, output s_ready);
endinterface

// File: rtl/pwm_frame_ctrl.sv
// Line sequencer for a PWM channel array: shifts in one line of pixel words,
// latches it into the compare registers and runs the shared prescaled count.
module pwm_frame_ctrl #(
  parameter int DWIDTH   = 8,
  parameter int STAGE    = 8,
  parameter int PRESCALE = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stop,
  pwm_frame_ctrl_if.slave   s_if,
  output logic              sh_en,
  output logic [DWIDTH-1:0] sh_data,
  output logic              latch,
  output logic [DWIDTH-1:0] count,
  output logic              pwm_run,
  output logic              frame_done,
  output logic              underrun
);
  localparam int WCW = $clog2(STAGE + 1);
  localparam int PW  = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [WCW-1:0]    WC_FULL  = WCW'(STAGE);
  localparam logic [PW-1:0]     PRE_LAST = PW'(PRESCALE - 1);
  localparam logic [DWIDTH-1:0] CNT_LAST = {DWIDTH{1'b1}};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    LATCH = 2'd2,
    RUN   = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [WCW-1:0]    wcnt_q, wcnt_d;
  logic [PW-1:0]     pre_q, pre_d;
  logic [DWIDTH-1:0] count_q, count_d;
  logic              stop_pending_q, stop_pending_d;
  logic              underrun_q, underrun_d;

  logic              ready_s;
  logic              xfer_s;
  logic              tick_s;
  logic              period_end_s;
  logic              latch_s;
  logic              frame_done_s;
  logic [WCW-1:0]    wcnt_inc_s;

  // Handshake qualification and prescaled period-end detection.
  always_comb begin
    ready_s      = ((state_q == FILL) || (state_q == RUN)) && (wcnt_q < WC_FULL);
    xfer_s       = s_if.s_valid && ready_s;
    wcnt_inc_s   = wcnt_q + WCW'(xfer_s);
    tick_s       = (state_q == RUN) && (pre_q == PRE_LAST);
    period_end_s = tick_s && (count_q == CNT_LAST);
  end

  // Next-state and strobe decode for the line sequencer.
  always_comb begin
    state_d        = state_q;
    wcnt_d         = wcnt_inc_s;
    pre_d          = pre_q;
    count_d        = count_q;
    stop_pending_d = stop_pending_q;
    underrun_d     = underrun_q;
    latch_s        = 1'b0;
    frame_done_s   = 1'b0;
    case (state_q)
      IDLE: begin
        wcnt_d         = '0;
        pre_d          = '0;
        count_d        = '0;
        stop_pending_d = 1'b0;
        if (start && !stop) begin
          state_d    = FILL;
          underrun_d = 1'b0;
        end else begin
          state_d = IDLE;
        end
      end
      FILL: begin
        // A stop discards the partial line; the next start needs a full line.
        if (stop) begin
          state_d = IDLE;
          wcnt_d  = '0;
        end else if (wcnt_inc_s == WC_FULL) begin
          state_d = LATCH;
        end else begin
          state_d = FILL;
        end
      end
      LATCH: begin
        latch_s = 1'b1;
        wcnt_d  = '0;
        pre_d   = '0;
        count_d = '0;
        state_d = RUN;
        if (stop) begin
          stop_pending_d = 1'b1;
        end else begin
          stop_pending_d = stop_pending_q;
        end
      end
      RUN: begin
        pre_d   = tick_s ? '0 : (pre_q + PW'(1'b1));
        count_d = tick_s ? (count_q + DWIDTH'(1'b1)) : count_q;
        if (period_end_s) begin
          frame_done_s = 1'b1;
          pre_d        = '0;
          count_d      = '0;
          if (stop_pending_q || stop) begin
            state_d        = IDLE;
            wcnt_d         = '0;
            stop_pending_d = 1'b0;
          end else if (wcnt_q == WC_FULL) begin
            // Seamless reload: the next line was ready in time.
            latch_s = 1'b1;
            wcnt_d  = '0;
            state_d = RUN;
          end else begin
            underrun_d = 1'b1;
            state_d    = FILL;
          end
        end else begin
          state_d = RUN;
          if (stop) begin
            stop_pending_d = 1'b1;
          end else begin
            stop_pending_d = stop_pending_q;
          end
        end
      end
      default: begin
        state_d        = IDLE;
        wcnt_d         = '0;
        pre_d          = '0;
        count_d        = '0;
        stop_pending_d = 1'b0;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      wcnt_q         <= '0;
      pre_q          <= '0;
      count_q        <= '0;
      stop_pending_q <= 1'b0;
      underrun_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      wcnt_q         <= wcnt_d;
      pre_q          <= pre_d;
      count_q        <= count_d;
      stop_pending_q <= stop_pending_d;
      underrun_q     <= underrun_d;
    end
  end

  assign s_if.s_ready = ready_s;
  assign sh_en        = xfer_s;
  assign sh_data      = s_if.s_data;
  assign latch        = latch_s;
  assign frame_done   = frame_done_s;
  assign count        = count_q;
  assign pwm_run      = (state_q == RUN);
  assign underrun     = underrun_q;
endmodule

// File: tb/tb_pwm_frame_ctrl.sv
// Self-checking bench for pwm_frame_ctrl: directed and random traffic against a
// timeline-based reference model, plus a minimal-size instance on continuous input.
module tb_pwm_frame_ctrl;
  localparam int DW  = 4;
  localparam int ST  = 3;
  localparam int PS  = 2;
  localparam int PER = (1 << DW) * PS;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A: DWIDTH=4, STAGE=3, PRESCALE=2
  logic          rst, start, stop;
  logic          sh_en, latch, pwm_run, frame_done, underrun;
  logic [DW-1:0] sh_data, count;
  pwm_frame_ctrl_if #(.DWIDTH(DW)) a_if ();

  pwm_frame_ctrl #(.DWIDTH(DW), .STAGE(ST), .PRESCALE(PS)) dut_a (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .s_if(a_if.slave),
    .sh_en(sh_en), .sh_data(sh_data), .latch(latch), .count(count),
    .pwm_run(pwm_run), .frame_done(frame_done), .underrun(underrun)
  );

  // Instance B: DWIDTH=2, STAGE=1, PRESCALE=1
  logic       rst_b, start_b, stop_b;
  logic       sh_en_b, latch_b, pwm_run_b, frame_done_b, underrun_b;
  logic [1:0] sh_data_b, count_b;
  pwm_frame_ctrl_if #(.DWIDTH(2)) b_if ();

  pwm_frame_ctrl #(.DWIDTH(2), .STAGE(1), .PRESCALE(1)) dut_b (
    .clk(clk), .rst(rst_b), .start(start_b), .stop(stop_b), .s_if(b_if.slave),
    .sh_en(sh_en_b), .sh_data(sh_data_b), .latch(latch_b), .count(count_b),
    .pwm_run(pwm_run_b), .frame_done(frame_done_b), .underrun(underrun_b)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: on/off, pending latch cycle, time into current period, words held.
  bit m_on, m_lat, m_spend, m_under;
  int m_run_t, m_words;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_on = 1'b0; m_lat = 1'b0; m_spend = 1'b0; m_under = 1'b0;
    m_run_t = -1; m_words = 0;
  endtask

  task automatic step_a(input bit r, input bit st, input bit sp, input bit v, input logic [DW-1:0] d);
    bit run_e, rdy_e, xfer_e, end_e, lat_e;
    int cnt_e;
    rst = r; start = st; stop = sp; a_if.s_valid = v; a_if.s_data = d;
    @(negedge clk);
    run_e  = m_on && !m_lat && (m_run_t >= 0);
    rdy_e  = m_on && !m_lat && (m_words < ST);
    xfer_e = v && rdy_e;
    end_e  = run_e && (m_run_t == PER - 1);
    cnt_e  = run_e ? ((m_run_t / PS) % (1 << DW)) : 0;
    lat_e  = m_lat || (end_e && !(m_spend || sp) && (m_words == ST));
    check("s_ready",    32'(a_if.s_ready), 32'(rdy_e));
    check("sh_en",      32'(sh_en),        32'(xfer_e));
    check("latch",      32'(latch),        32'(lat_e));
    check("count",      32'(count),        32'(cnt_e));
    check("pwm_run",    32'(pwm_run),      32'(run_e));
    check("frame_done", 32'(frame_done),   32'(end_e));
    check("underrun",   32'(underrun),     32'(m_under));
    if (xfer_e) check("sh_data", 32'(sh_data), 32'(d));
    if (r) begin
      model_reset();
    end else if (!m_on) begin
      if (st && !sp) begin
        m_on = 1'b1; m_under = 1'b0; m_words = 0; m_run_t = -1;
      end
    end else if (m_lat) begin
      m_lat = 1'b0; m_words = 0; m_run_t = 0;
      if (sp) m_spend = 1'b1;
    end else if (m_run_t < 0) begin
      if (sp) begin
        m_on = 1'b0; m_words = 0;
      end else begin
        m_words += int'(xfer_e);
        if (m_words == ST) m_lat = 1'b1;
      end
    end else if (end_e) begin
      if (m_spend || sp) begin
        m_on = 1'b0; m_words = 0; m_spend = 1'b0; m_run_t = -1;
      end else if (m_words == ST) begin
        m_words = 0; m_run_t = 0;
      end else begin
        m_under = 1'b1; m_run_t = -1; m_words += int'(xfer_e);
      end
    end else begin
      m_run_t++;
      m_words += int'(xfer_e);
      if (sp) m_spend = 1'b1;
    end
    @(posedge clk); #1;
  endtask

  task automatic idle_a(input int n);
    for (int i = 0; i < n; i++) step_a(1'b0, 1'b0, 1'b0, 1'b0, '0);
  endtask

  task automatic word_a(input logic [DW-1:0] d);
    step_a(1'b0, 1'b0, 1'b0, 1'b1, d);
  endtask

  task automatic wait_count_a(input logic [DW-1:0] c, input string tag);
    for (int i = 0; i < 80 && count != c; i++) idle_a(1);
    check(tag, 32'(count), 32'(c));
  endtask

  initial begin
    bit fd_e, lat_e, sh_e;
    int cnt_e;
    rst = 1'b1; start = 1'b0; stop = 1'b0; a_if.s_valid = 1'b0; a_if.s_data = '0;
    rst_b = 1'b1; start_b = 1'b0; stop_b = 1'b0; b_if.s_valid = 1'b0; b_if.s_data = '0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();

    // Reset state, first line 1,2,3, then a next line supplied mid-period.
    step_a(1'b1, 1'b0, 1'b0, 1'b0, '0);
    step_a(1'b0, 1'b1, 1'b0, 1'b0, '0);
    word_a(4'h1); word_a(4'h2); word_a(4'h3);
    idle_a(10);
    word_a(4'h4); word_a(4'h5); word_a(4'h6);
    idle_a(40);

    // Underrun: two words only, third word arrives after the period ended.
    word_a(4'h7); word_a(4'h8);
    for (int i = 0; i < 80 && underrun !== 1'b1; i++) idle_a(1);
    check("wait_underrun", 32'(underrun), 32'd1);
    idle_a(4);
    word_a(4'h9);
    idle_a(6);

    // Stop at count 7 with the next line already full.
    word_a(4'hA); word_a(4'hB); word_a(4'hC);
    wait_count_a(4'd7, "wait_count7");
    step_a(1'b0, 1'b0, 1'b1, 1'b0, '0);
    for (int i = 0; i < 80 && pwm_run !== 1'b0; i++) idle_a(1);
    check("wait_stop_idle", 32'(pwm_run), 32'd0);
    idle_a(3);

    // Stop during FILL after one word, then a fresh start needs three words.
    step_a(1'b0, 1'b1, 1'b0, 1'b0, '0);
    word_a(4'hD);
    step_a(1'b0, 1'b0, 1'b1, 1'b0, '0);
    idle_a(2);
    step_a(1'b0, 1'b1, 1'b0, 1'b0, '0);
    word_a(4'hE); word_a(4'hF); word_a(4'h1);
    idle_a(4);

    // Reset mid-period at count 9, then in FILL after two words; s_valid held high.
    wait_count_a(4'd9, "wait_count9");
    step_a(1'b1, 1'b0, 1'b0, 1'b1, 4'h5);
    for (int i = 0; i < 3; i++) step_a(1'b0, 1'b0, 1'b0, 1'b1, 4'h5);
    step_a(1'b0, 1'b1, 1'b0, 1'b0, '0);
    word_a(4'h2); word_a(4'h3);
    step_a(1'b1, 1'b0, 1'b0, 1'b1, 4'h4);
    for (int i = 0; i < 3; i++) step_a(1'b0, 1'b0, 1'b0, 1'b1, 4'h4);

    // Random traffic.
    for (int i = 0; i < 1500; i++) begin
      step_a(($urandom_range(399) == 0), ($urandom_range(29) == 0), ($urandom_range(59) == 0),
             ($urandom_range(9) < 6), DW'($urandom));
    end

    // Instance B: continuous input, one word per line, count period of 4 cycles.
    rst_b = 1'b0; start_b = 1'b1;
    @(posedge clk); #1;
    start_b = 1'b0; b_if.s_valid = 1'b1;
    for (int k = 0; k < 24; k++) begin
      b_if.s_data = 2'(k);
      @(negedge clk);
      fd_e  = (k >= 2) && ((k - 2) % 4 == 3);
      lat_e = (k == 1) || fd_e;
      sh_e  = (k == 0) || ((k >= 2) && ((k - 2) % 4 == 0));
      cnt_e = (k >= 2) ? ((k - 2) % 4) : 0;
      check("b_latch",      32'(latch_b),      32'(lat_e));
      check("b_frame_done", 32'(frame_done_b), 32'(fd_e));
      check("b_sh_en",      32'(sh_en_b),      32'(sh_e));
      check("b_count",      32'(count_b),      32'(cnt_e));
      check("b_pwm_run",    32'(pwm_run_b),    32'(k >= 2));
      check("b_underrun",   32'(underrun_b),   32'd0);
      if (sh_e) check("b_sh_data", 32'(sh_data_b), 32'(k % 4));
      @(posedge clk); #1;
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
